// File: rtl/pll_pkg.sv
// pll_pkg: shared widths, default timing constants and sequencer state encoding
package pll_pkg;
    localparam int PLL_DIV_W = 5;
    localparam int PLL_TRIM_W = 26;
    localparam int DEF_STABLE_CYCLES = 5;
    localparam int DEF_MAX_WAIT_CYCLES = 50;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_UNLOCK_CHANGES = 3;
    localparam int DEF_DIV_MIN = 2;
    typedef enum logic [2:0] {IDLE, SETTLE, TRACK, LOCKED, FAIL} pll_state_t;
endpackage

// File: rtl/pll_trim_stability.sv
// pll_trim_stability: watches the trim word, flagging lock-worthy stability in
// TRACK and excessive trim activity in LOCKED
module pll_trim_stability
    import pll_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int UNLOCK_CHANGES = DEF_UNLOCK_CHANGES
) (
    input  logic                  osc,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  track,
    input  logic                  lock,
    input  logic [PLL_TRIM_W-1:0] trim,
    output logic                  stable_hit,
    output logic                  unlock_hit
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int UW = $clog2(UNLOCK_CHANGES + 1);
    logic [PLL_TRIM_W-1:0] prev_trim;
    logic [SW-1:0] stable_cnt;
    logic [UW-1:0] unlock_cnt;
    logic same, stable_full;
    // hits look at the post-sample count so the transition lands on this edge
    always_comb begin
        same = trim == prev_trim;
        stable_full = same && (int'(stable_cnt) + 1 >= STABLE_CYCLES);
        stable_hit = track && stable_full;
        unlock_hit = lock && !same && (int'(unlock_cnt) + 1 >= UNLOCK_CHANGES);
    end
    always_ff @(posedge osc) begin
        if (reset) begin
            prev_trim <= '0;
            stable_cnt <= '0;
            unlock_cnt <= '0;
        end else begin
            if (load || ((track || lock) && !same)) begin
                prev_trim <= trim;
                stable_cnt <= '0;
            end else if (track || lock) begin
                stable_cnt <= stable_full ? SW'(STABLE_CYCLES) : stable_cnt + 1'b1;
            end
            unlock_cnt <= (!lock || unlock_hit || stable_full) ? '0 :
                          !same ? unlock_cnt + 1'b1 : unlock_cnt;
        end
    end
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: digital_pll acquisition FSM with lock, timeout and unlock detection.
// Define PLL_SEQ_DCO_FALLBACK_EN to freeze the DCO open-loop on timeout.
module pll_lock_sequencer
    import pll_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_WAIT_CYCLES = DEF_MAX_WAIT_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int UNLOCK_CHANGES = DEF_UNLOCK_CHANGES,
    parameter int DIV_MIN = DEF_DIV_MIN
) (
    input  logic                  osc,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [PLL_DIV_W-1:0]  req_div,
    output logic                  req_ready,
    input  logic [PLL_TRIM_W-1:0] trim,
    output logic                  pll_enable,
    output logic [PLL_DIV_W-1:0]  pll_div,
    output logic                  pll_dco,
    output logic [PLL_TRIM_W-1:0] pll_ext_trim,
    output logic                  busy,
    output logic                  locked,
    output logic                  timeout,
    output logic                  req_err,
    output logic [7:0]            lock_cycles
);
    localparam int WW = $clog2(MAX_WAIT_CYCLES + 1);
    pll_state_t state, state_n;
    logic [WW-1:0] wait_cnt;
    logic accept, start, active, settle_done, expired, stable_hit, unlock_hit;
    pll_trim_stability #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .UNLOCK_CHANGES(UNLOCK_CHANGES)
    ) u_stab (
        .osc(osc),
        .reset(reset),
        .load(settle_done),
        .track(state == TRACK),
        .lock(state == LOCKED),
        .trim(trim),
        .stable_hit(stable_hit),
        .unlock_hit(unlock_hit)
    );
    // the budget includes the accept cycle, so the final cycle sees MAX-2 elapsed
    always_comb begin
        req_ready = state == IDLE || state == LOCKED || state == FAIL;
        accept = req_valid && req_ready;
        start = accept && int'(req_div) >= DIV_MIN;
        active = state == SETTLE || state == TRACK;
        settle_done = state == SETTLE && int'(wait_cnt) >= SETTLE_CYCLES - 1;
        expired = active && int'(wait_cnt) >= MAX_WAIT_CYCLES - 2;
        state_n = state;
        if (start) state_n = SETTLE;
        else if (stable_hit) state_n = LOCKED;
        else if (expired) state_n = FAIL;
        else if (settle_done || unlock_hit) state_n = TRACK;
    end
    always_ff @(posedge osc) begin
        if (reset) begin
            state <= IDLE;
            wait_cnt <= '0;
            pll_enable <= 1'b0;
            pll_div <= PLL_DIV_W'(DIV_MIN);
            busy <= 1'b0;
            locked <= 1'b0;
            timeout <= 1'b0;
            req_err <= 1'b0;
            lock_cycles <= '0;
        end else begin
            state <= state_n;
            wait_cnt <= (start || unlock_hit) ? '0 : active ? wait_cnt + 1'b1 : wait_cnt;
            busy <= state_n == SETTLE || state_n == TRACK;
            locked <= state_n == LOCKED;
            timeout <= state_n == FAIL;
            req_err <= accept && !start;
            if (start) begin
                pll_enable <= 1'b1;
                pll_div <= req_div;
            end
            lock_cycles <= start ? '0 : (active && lock_cycles != 8'hff) ? lock_cycles + 1'b1 : lock_cycles;
        end
    end
`ifdef PLL_SEQ_DCO_FALLBACK_EN
    // trim is what prev_trim captures on the failing edge
    always_ff @(posedge osc) begin
        if (reset) begin
            pll_dco <= 1'b0;
            pll_ext_trim <= '0;
        end else if (start) begin
            pll_dco <= 1'b0;
        end else if (state_n == FAIL && state != FAIL) begin
            pll_dco <= 1'b1;
            pll_ext_trim <= trim;
        end
    end
`else
    assign pll_dco = 1'b0;
    assign pll_ext_trim = '0;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed checks of acquisition, reject, unlock/relock,
// held requests, timeout and mid-acquisition reset
module tb_pll_lock_sequencer;
    logic osc, reset, req_valid, req_ready, pll_enable, pll_dco;
    logic busy, locked, timeout, req_err;
    logic [4:0] req_div, pll_div;
    logic [25:0] trim, pll_ext_trim, last_trim;
    logic [7:0] lock_cycles;
    int checks = 0;
    int errors = 0;
    pll_lock_sequencer dut (
        .osc(osc), .reset(reset), .req_valid(req_valid), .req_div(req_div),
        .req_ready(req_ready), .trim(trim), .pll_enable(pll_enable),
        .pll_div(pll_div), .pll_dco(pll_dco), .pll_ext_trim(pll_ext_trim),
        .busy(busy), .locked(locked), .timeout(timeout), .req_err(req_err),
        .lock_cycles(lock_cycles)
    );
    initial osc = 1'b0;
    always #5 osc = ~osc;
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge osc);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        reset = 1'b1; req_valid = 1'b0; req_div = 5'd0; trim = 26'h0abcdef;
        tick(2);
        chk("rst_enable", 32'(pll_enable), 0);
        chk("rst_div", 32'(pll_div), 2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_req_err", 32'(req_err), 0);
        chk("rst_lock_cycles", 32'(lock_cycles), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_dco", 32'(pll_dco), 0);
        chk("rst_ext_trim", 32'(pll_ext_trim), 0);
        reset = 1'b0;
        tick();
        // accept 17 with constant trim: lock at accept+8, lock_cycles 7
        req_valid = 1'b1; req_div = 5'd17;
        tick();
        req_valid = 1'b0;
        chk("acc_busy", 32'(busy), 1);
        chk("acc_div", 32'(pll_div), 17);
        chk("acc_enable", 32'(pll_enable), 1);
        chk("acc_ready", 32'(req_ready), 0);
        tick(6);
        chk("lock_early", 32'(locked), 0);
        tick();
        chk("lock_at8", 32'(locked), 1);
        chk("lock_cycles7", 32'(lock_cycles), 7);
        chk("lock_busy", 32'(busy), 0);
        chk("lock_ready", 32'(req_ready), 1);
        // illegal divider while locked
        req_valid = 1'b1; req_div = 5'd1;
        tick();
        req_valid = 1'b0;
        chk("ill_err", 32'(req_err), 1);
        chk("ill_locked", 32'(locked), 1);
        chk("ill_div", 32'(pll_div), 17);
        chk("ill_busy", 32'(busy), 0);
        tick();
        chk("ill_err_pulse", 32'(req_err), 0);
        // three trim changes in a row drop lock, then relock on stable trim
        trim = 26'h0000a1;
        tick();
        trim = 26'h0000b2;
        tick();
        trim = 26'h0000c3;
        chk("unl_still", 32'(locked), 1);
        tick();
        chk("unl_locked", 32'(locked), 0);
        chk("unl_busy", 32'(busy), 1);
        tick(4);
        chk("relock_early", 32'(locked), 0);
        tick();
        chk("relock", 32'(locked), 1);
        chk("relock_cycles", 32'(lock_cycles), 12);
        // re-accept from LOCKED, then hold a request through acquisition
        req_valid = 1'b1; req_div = 5'd9;
        tick();
        req_div = 5'd20;
        chk("reacq_locked", 32'(locked), 0);
        chk("reacq_busy", 32'(busy), 1);
        chk("reacq_div", 32'(pll_div), 9);
        chk("hold_ready", 32'(req_ready), 0);
        tick(7);
        chk("hold_locked", 32'(locked), 1);
        chk("hold_div", 32'(pll_div), 9);
        chk("hold_cycles", 32'(lock_cycles), 7);
        tick();
        req_valid = 1'b0;
        chk("held_busy", 32'(busy), 1);
        chk("held_div", 32'(pll_div), 20);
        chk("held_cycles", 32'(lock_cycles), 0);
        // toggling trim: timeout at accept+50
        for (int i = 0; i < 48; i++) begin
            trim = 26'h100000 + 26'(i);
            tick();
        end
        chk("to_early", 32'(timeout), 0);
        chk("to_early_busy", 32'(busy), 1);
        trim = 26'h200000;
        last_trim = trim;
        tick();
        chk("to_timeout", 32'(timeout), 1);
        chk("to_ready", 32'(req_ready), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_cycles", 32'(lock_cycles), 49);
`ifdef PLL_SEQ_DCO_FALLBACK_EN
        chk("to_dco", 32'(pll_dco), 1);
        chk("to_ext_trim", 32'(pll_ext_trim), 32'(last_trim));
`else
        chk("to_dco", 32'(pll_dco), 0);
        chk("to_ext_trim", 32'(pll_ext_trim), 0);
`endif
        // accept from FAIL, then reset during TRACK
        trim = 26'h000003;
        req_valid = 1'b1; req_div = 5'd17;
        tick();
        req_valid = 1'b0;
        chk("fail_acc_timeout", 32'(timeout), 0);
        chk("fail_acc_busy", 32'(busy), 1);
        chk("fail_acc_dco", 32'(pll_dco), 0);
        tick(3);
        chk("track_busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_enable", 32'(pll_enable), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_timeout", 32'(timeout), 0);
        chk("mrst_cycles", 32'(lock_cycles), 0);
        chk("mrst_div", 32'(pll_div), 2);
        chk("mrst_ready", 32'(req_ready), 1);
        // DIV_MIN itself is legal
        tick();
        req_valid = 1'b1; req_div = 5'd2;
        tick();
        req_valid = 1'b0;
        chk("min_busy", 32'(busy), 1);
        chk("min_err", 32'(req_err), 0);
        chk("min_enable", 32'(pll_enable), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
